// File: rtl/fifo_drain_ctrl_if.sv
// FIFO pop-side and downstream valid/ready bundle for fifo_drain_ctrl.
// master = the drain controller, slave = the FIFO/sink environment.
interface fifo_drain_ctrl_if #(
    parameter int width = 16
);
    logic             pndng;
    logic [width-1:0] Dout;
    logic             pop;
    logic [width-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        input  pndng,
        input  Dout,
        output pop,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        output pndng,
        output Dout,
        input  pop,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/fifo_drain_ctrl.sv
// Drains a programmed burst from a FWFT FIFO into a 2-entry
// output buffer feeding a valid/ready sink.
module fifo_drain_ctrl #(
    parameter int width = 16,
    parameter int cnt_w = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [cnt_w-1:0]      len,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [cnt_w-1:0]      rd_count,
    fifo_drain_ctrl_if.master     bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    state_t           state;
    logic [cnt_w-1:0] remaining;

    logic [width-1:0] mem [2];
    logic             head;
    logic [1:0]       occ;

    logic             wr;
    logic             rd;
    logic             space;
    logic             tail;

    assign bus.out_valid = (occ != 2'd0);
    assign bus.out_data  = mem[head];

    assign rd    = bus.out_valid & bus.out_ready;
    // A full buffer still has room when its head leaves this edge.
    assign space = (occ < 2'd2) | rd;
    assign tail  = head ^ occ[0];

    assign bus.pop = (state == RUN) & bus.pndng
                   & (remaining != '0) & ~abort & space;
    assign wr = bus.pop;

    // Output buffer: write at tail on pop, advance head on handoff.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            head   <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (wr)
                mem[tail] <= bus.Dout;
            if (rd)
                head <= ~head;
            if (wr & ~rd)
                occ <= occ + 2'd1;
            else if (~wr & rd)
                occ <= occ - 2'd1;
        end
    end

    // Burst FSM with registered busy/done and the pop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_count  <= '0;
        end else begin
            done <= 1'b0;
            if (wr)
                rd_count <= rd_count + cnt_w'(1);
            unique case (state)
                IDLE: begin
                    if (start && (len != '0)) begin
                        state     <= RUN;
                        remaining <= len;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state     <= FLUSH;
                        remaining <= '0;
                    end else if (remaining == '0) begin
                        state <= FLUSH;
                    end else if (wr) begin
                        remaining <= remaining - cnt_w'(1);
                    end
                end
                FLUSH: begin
                    if (occ == 2'd0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Scoreboard bench for fifo_drain_ctrl: a queue-based FIFO drives
// the pop side, a reference model predicts the delivered words.
module tb_fifo_drain_ctrl;

    localparam int W  = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] len = '0;
    logic          busy;
    logic          done;
    logic [CW-1:0] rd_count;

    fifo_drain_ctrl_if #(.width(W)) bus ();

    fifo_drain_ctrl #(.width(W), .cnt_w(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .rd_count (rd_count),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0]  fifo_q[$];
    logic [W-1:0]  push_q[$];
    logic [W-1:0]  ref_fifo[$];
    logic [W-1:0]  exp_q[$];
    int            pending = 0;
    logic [CW-1:0] exp_rd = '0;
    int            done_cnt = 0;
    int            pop_cnt = 0;
    logic          pop_cap = 1'b0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Environment FIFO: first-word-fall-through over a queue.
    initial begin
        bus.pndng = 1'b0;
        bus.Dout  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (pop_cap && fifo_q.size() > 0)
                void'(fifo_q.pop_front());
            while (push_q.size() > 0)
                fifo_q.push_back(push_q.pop_front());
            bus.pndng = (fifo_q.size() != 0);
            bus.Dout  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        end
    end

    // Monitor: compares every handoff against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (done)
                done_cnt++;
            if (bus.pop) begin
                pop_cnt++;
                chk("pop_gated", {63'd0, bus.pndng}, 64'd1);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got %0h expected none",
                             bus.out_data);
                end else begin
                    chk("out_data", {48'd0, bus.out_data}, {48'd0, exp_q.pop_front()});
                end
            end
        end
        pop_cap = bus.pop;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_word(logic [W-1:0] w);
        push_q.push_back(w);
        if (pending > 0) begin
            exp_q.push_back(w);
            pending--;
            exp_rd++;
        end else begin
            ref_fifo.push_back(w);
        end
    endtask

    // A burst of n words delivers the next n words in arrival order.
    task automatic model_start(int n);
        pending = n;
        while (pending > 0 && ref_fifo.size() > 0) begin
            exp_q.push_back(ref_fifo.pop_front());
            pending--;
            exp_rd++;
        end
    endtask

    task automatic issue_start(logic [CW-1:0] l);
        start = 1'b1;
        len   = l;
        step();
        start = 1'b0;
        len   = '0;
    endtask

    task automatic wait_done(string name, int d0, int budget);
        int i;
        i = 0;
        while (done_cnt == d0 && i < budget) begin
            step();
            i++;
        end
        step(2);
        chk({name, "_done"}, done_cnt, d0 + 1);
        chk({name, "_busy"}, {63'd0, busy}, 64'd0);
        chk({name, "_drained"}, exp_q.size(), 64'd0);
        chk({name, "_rd_count"}, {56'd0, rd_count}, {56'd0, exp_rd});
    endtask

    initial begin
        int d0;
        int p0;
        int l;
        int pre;
        bus.out_ready = 1'b1;

        // Reset held with words waiting in the FIFO.
        for (int i = 1; i <= 4; i++)
            push_word(W'(i));
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_pop", {63'd0, bus.pop}, 64'd0);
            chk("rst_valid", {63'd0, bus.out_valid}, 64'd0);
            chk("rst_busy", {63'd0, busy}, 64'd0);
            chk("rst_rd_count", {56'd0, rd_count}, 64'd0);
        end
        rst = 1'b0;
        step();
        chk("rel_pop", {63'd0, bus.pop}, 64'd0);
        chk("rel_busy", {63'd0, busy}, 64'd0);
        chk("rel_data", {48'd0, bus.out_data}, 64'd0);

        // Basic burst of 4 at full rate.
        d0 = done_cnt;
        model_start(4);
        issue_start(8'd4);
        for (int i = 0; i < 4; i++) begin
            chk("basic_pop", {63'd0, bus.pop}, 64'd1);
            step();
        end
        chk("basic_pop_end", {63'd0, bus.pop}, 64'd0);
        wait_done("basic", d0, 50);

        // Backpressure: only the buffer depth is popped.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            push_word(W'(16'h0100 + i));
        step(3);
        d0 = done_cnt;
        p0 = pop_cnt;
        model_start(5);
        issue_start(8'd5);
        step(6);
        chk("bp_pops", pop_cnt - p0, 64'd2);
        chk("bp_pop_low", {63'd0, bus.pop}, 64'd0);
        chk("bp_hold", {48'd0, bus.out_data}, 64'h0100);
        step();
        chk("bp_hold2", {48'd0, bus.out_data}, 64'h0100);
        bus.out_ready = 1'b1;
        wait_done("bp", d0, 50);

        // Starvation, with an ignored start mid-burst.
        d0 = done_cnt;
        model_start(3);
        issue_start(8'd3);
        step(3);
        chk("starve_busy", {63'd0, busy}, 64'd1);
        chk("starve_pop", {63'd0, bus.pop}, 64'd0);
        push_word(16'hAAAA);
        step(4);
        issue_start(8'd7);
        push_word(16'hBBBB);
        step(5);
        chk("starve_busy2", {63'd0, busy}, 64'd1);
        push_word(16'hCCCC);
        wait_done("starve", d0, 50);

        // Zero length start is a no-op.
        d0 = done_cnt;
        issue_start(8'd0);
        step(2);
        chk("len0_busy", {63'd0, busy}, 64'd0);
        chk("len0_done", done_cnt, d0);

        // Abort after the third pop.
        for (int i = 0; i < 8; i++)
            push_word(W'(16'h0200 + i));
        step(3);
        d0 = done_cnt;
        p0 = pop_cnt;
        model_start(3);
        issue_start(8'd8);
        step(3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        wait_done("abort", d0, 50);
        chk("abort_pops", pop_cnt - p0, 64'd3);
        chk("abort_fifo_left", fifo_q.size(), 64'd5);

        d0 = done_cnt;
        model_start(5);
        issue_start(8'd5);
        wait_done("leftover", d0, 50);

        // Randomised bursts; cumulative pops pass the counter wrap.
        for (int b = 0; b < 30; b++) begin
            l   = $urandom_range(8, 30);
            pre = $urandom_range(0, l);
            for (int i = 0; i < pre; i++)
                push_word(W'($urandom));
            step(2);
            d0 = done_cnt;
            model_start(l);
            issue_start(CW'(l));
            for (int c = 0; c < 3000 && done_cnt == d0; c++) begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
                if (pending > 0 && $urandom_range(0, 2) == 0)
                    push_word(W'($urandom));
                step();
            end
            bus.out_ready = 1'b1;
            wait_done("rand", d0, 200);
        end

        // Reset mid-burst: one word delivered, one lost in the buffer.
        for (int i = 0; i < 6; i++)
            push_word(W'(16'h0300 + i));
        step(3);
        model_start(1);
        issue_start(8'd6);
        step(2);
        rst = 1'b1;
        #1;
        void'(ref_fifo.pop_front());
        pending = 0;
        exp_rd  = '0;
        chk("mid_rst_pop", {63'd0, bus.pop}, 64'd0);
        chk("mid_rst_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("mid_rst_data", {48'd0, bus.out_data}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_done", {63'd0, done}, 64'd0);
        chk("mid_rst_rd_count", {56'd0, rd_count}, 64'd0);
        chk("mid_rst_delivered", exp_q.size(), 64'd0);
        step();
        rst = 1'b0;
        step(2);
        chk("mid_rst_fifo_left", fifo_q.size(), 64'd4);
        d0 = done_cnt;
        l  = ref_fifo.size();
        model_start(l);
        issue_start(CW'(l));
        wait_done("post_rst", d0, 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
